// File: rtl/dmem_responder_pkg.sv
// Local types for the data-memory responder: transaction tags and the
// {valid, tag, data} record carried down the load-return pipeline.
package dmem_responder_pkg;

  typedef logic [3:0] tag_t;

  localparam tag_t TAG_FIRST = 4'd1;
  localparam tag_t TAG_LAST  = 4'd15;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [63:0] data;
  } ret_entry_t;

  // Tags cycle 1..15 so that 0 stays free to mean "nothing".
  function automatic tag_t tag_advance(input tag_t t);
    return (t == TAG_LAST) ? TAG_FIRST : t + 4'd1;
  endfunction

endpackage

// File: rtl/sys_defs.sv
// Shared system-wide definitions: bus command encoding, address type and
// memory model defaults used by the data-memory responder and its clients.
package sys_defs;

  typedef logic [31:0] PC_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  localparam int MEM_LATENCY_DEFAULT = 4;
  localparam int MEM_WORDS_DEFAULT   = 64;

endpackage

// File: rtl/dmem_responder_if.sv
// D-cache <-> data-memory bus: request/backpressure from the cache side,
// acceptance tag and tagged load return from the memory side.
interface dmem_responder_if;
  import sys_defs::*;

  BUS_COMMAND  Dcache2Dmem_command;
  PC_t         Dcache2Dmem_addr;
  logic [63:0] Dcache2Dmem_data;
  logic        mem_busy;
  logic [3:0]  Dmem2Dcache_response;
  logic [63:0] Dmem2Dcache_data;
  logic [3:0]  Dmem2Dcache_tag;

  modport master (
    output Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data, mem_busy,
    input  Dmem2Dcache_response, Dmem2Dcache_data, Dmem2Dcache_tag
  );

  modport slave (
    input  Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data, mem_busy,
    output Dmem2Dcache_response, Dmem2Dcache_data, Dmem2Dcache_tag
  );

endinterface

// File: rtl/dmem_return_pipe.sv
// Fixed-depth shift register of load-return records; entries leave in the
// order they entered, DEPTH cycles later. Cleared asynchronously by reset.
module dmem_return_pipe
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  ret_entry_t in_entry,
  output ret_entry_t out_entry
);

  ret_entry_t stage_reg  [DEPTH];
  ret_entry_t stage_next [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = in_entry;
      end else begin : g_body
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign out_entry = stage_reg[DEPTH-1];

endmodule

// File: rtl/dmem_responder.sv
// Behavioural data memory for the D-cache: accepts one tagged load/store per
// cycle and returns each load's snapshot MEM_LATENCY cycles after acceptance.
module dmem_responder
  import sys_defs::*;
  import dmem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT,
  parameter int MEM_WORDS   = MEM_WORDS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(MEM_WORDS);

  tag_t        tag_cnt_reg;
  logic [63:0] mem_reg [MEM_WORDS];
  logic [AW-1:0] word_idx;
  logic        accept;
  logic        accept_load;
  logic        accept_store;
  ret_entry_t  pipe_in;
  ret_entry_t  pipe_out;

  // Upper address bits are dropped, so addresses alias modulo the store size.
  assign word_idx = bus.Dcache2Dmem_addr[3 +: AW];

  always_comb begin
    accept       = 1'b0;
    accept_load  = 1'b0;
    accept_store = 1'b0;
    if (reset && !bus.mem_busy) begin
      accept_load  = (bus.Dcache2Dmem_command == BUS_LOAD);
      accept_store = (bus.Dcache2Dmem_command == BUS_STORE);
      accept       = accept_load || accept_store;
    end
  end

  assign bus.Dmem2Dcache_response = accept ? tag_cnt_reg : 4'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_cnt_reg <= TAG_FIRST;
    end else if (accept) begin
      tag_cnt_reg <= tag_advance(tag_cnt_reg);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (accept_store) begin
      mem_reg[word_idx] <= bus.Dcache2Dmem_data;
    end
  end

  // The load reads the pre-edge contents; only one request lands per edge,
  // so there is never a same-edge store to forward.
  always_comb begin
    pipe_in = '0;
    if (accept_load) begin
      pipe_in.valid = 1'b1;
      pipe_in.tag   = tag_cnt_reg;
      pipe_in.data  = mem_reg[word_idx];
    end
  end

  dmem_return_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_return_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_entry  (pipe_in),
    .out_entry (pipe_out)
  );

  assign bus.Dmem2Dcache_tag  = pipe_out.valid ? pipe_out.tag  : 4'd0;
  assign bus.Dmem2Dcache_data = pipe_out.valid ? pipe_out.data : 64'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, a back-to-back load run and
// random traffic, all checked against a queue/array reference model.
module tb_dmem_responder;
  import sys_defs::*;

  localparam int LAT   = 4;
  localparam int WORDS = 64;
  localparam int AW    = $clog2(WORDS);

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  dmem_responder_if bus();

  dmem_responder #(
    .MEM_LATENCY (LAT),
    .MEM_WORDS   (WORDS)
  ) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: flat word array, next-tag integer, queue of due loads.
  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } pend_t;

  logic [63:0] m_mem [WORDS];
  int          m_next_tag = 1;
  pend_t       pend_q[$];

  typedef struct {
    logic        r;
    BUS_COMMAND  c;
    logic        b;
    logic [31:0] a;
    logic [63:0] d;
    logic [3:0]  exp_resp;
    logic [3:0]  exp_tag;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic r, input BUS_COMMAND c, input logic b,
                              input logic [31:0] a, input logic [63:0] d,
                              input logic [3:0] er, input logic [3:0] et, input logic [63:0] ed);
    vec_t v;
    v.r = r; v.c = c; v.b = b; v.a = a; v.d = d;
    v.exp_resp = er; v.exp_tag = et; v.exp_data = ed;
    return v;
  endfunction

  // One bus cycle: drive after the falling edge, compare to the model,
  // then let the rising edge happen and update the model.
  task automatic step(input logic r, input BUS_COMMAND c, input logic b,
                      input logic [31:0] a, input logic [63:0] d,
                      output logic [3:0] resp, output logic [3:0] tag, output logic [63:0] data);
    logic [3:0]    e_resp;
    logic [3:0]    e_tag;
    logic [63:0]   e_data;
    logic [AW-1:0] idx;
    @(negedge clock);
    rst_n = r;
    bus.Dcache2Dmem_command = c;
    bus.Dcache2Dmem_addr    = a;
    bus.Dcache2Dmem_data    = d;
    bus.mem_busy            = b;
    #1;
    if (!r) begin
      for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
      pend_q.delete();
      m_next_tag = 1;
    end
    e_resp = (r && !b && (c == BUS_LOAD || c == BUS_STORE)) ? 4'(m_next_tag) : 4'd0;
    e_tag  = 4'd0;
    e_data = 64'd0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      e_tag  = pend_q[0].tag;
      e_data = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    resp = bus.Dmem2Dcache_response;
    tag  = bus.Dmem2Dcache_tag;
    data = bus.Dmem2Dcache_data;
    check("model_resp", 64'(resp), 64'(e_resp));
    check("model_tag",  64'(tag),  64'(e_tag));
    check("model_data", data, e_data);
    if (resp != 0 || tag != 0)
      $display("cyc %0d rst_n=%0b cmd=%s busy=%0b addr=%h -> resp=%0d tag=%0d data=%h",
               cyc, r, c.name(), b, a, resp, tag, data);
    @(posedge clock);
    if (e_resp != 0) begin
      idx = a[3 +: AW];
      if (c == BUS_LOAD) pend_q.push_back('{cyc + LAT, e_resp, m_mem[idx]});
      else               m_mem[idx] = d;
      m_next_tag = (m_next_tag == 15) ? 1 : m_next_tag + 1;
    end
    cyc++;
  endtask

  initial begin
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] data;

    bus.Dcache2Dmem_command = BUS_NONE;
    bus.Dcache2Dmem_addr    = '0;
    bus.Dcache2Dmem_data    = '0;
    bus.mem_busy            = 1'b0;
    for (int i = 0; i < WORDS; i++) m_mem[i] = '0;

    // Reset, then single load latency.
    vecs.push_back(mk(0, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(0, BUS_LOAD,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_LOAD,  0, 32'h8,   64'h0, 1, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 1, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    // Store then load of the same word; the store's tag never returns.
    vecs.push_back(mk(0, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_STORE, 0, 32'h10,  64'hDEAD_BEEF_0123_4567, 1, 0, 64'h0));
    vecs.push_back(mk(1, BUS_LOAD,  0, 32'h10,  64'h0, 2, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 2, 64'hDEAD_BEEF_0123_4567));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    // Address aliasing: 0x200 and 0x0 share word 0.
    vecs.push_back(mk(1, BUS_STORE, 0, 32'h200, 64'h55, 3, 0, 64'h0));
    vecs.push_back(mk(1, BUS_LOAD,  0, 32'h0,   64'h0, 4, 0, 64'h0));
    vecs.push_back(mk(1, BUS_LOAD,  0, 32'h200, 64'h0, 5, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 4, 64'h55));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 5, 64'h55));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    // Backpressure: nothing accepted, no store lands, counter holds.
    vecs.push_back(mk(1, BUS_STORE, 1, 32'h200, 64'hAA, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_LOAD,  1, 32'h200, 64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_LOAD,  1, 32'h200, 64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_LOAD,  0, 32'h200, 64'h0, 6, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 6, 64'h55));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    // Reset mid-flight discards the load; numbering restarts at 1.
    vecs.push_back(mk(1, BUS_LOAD,  0, 32'h0,   64'h0, 7, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(0, BUS_LOAD,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_LOAD,  0, 32'h0,   64'h0, 1, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 1, 64'h0));
    vecs.push_back(mk(1, BUS_NONE,  0, 32'h0,   64'h0, 0, 0, 64'h0));

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].c, vecs[k].b, vecs[k].a, vecs[k].d, resp, tag, data);
      check($sformatf("vec%0d_resp", k), 64'(resp), 64'(vecs[k].exp_resp));
      check($sformatf("vec%0d_tag", k),  64'(tag),  64'(vecs[k].exp_tag));
      check($sformatf("vec%0d_data", k), data, vecs[k].exp_data);
    end

    // Back-to-back loads: tag wrap 15 -> 1 and one completion per cycle.
    step(0, BUS_NONE, 0, 32'h0, 64'h0, resp, tag, data);
    for (int i = 0; i < 24; i++) begin
      step(1, (i < 20) ? BUS_LOAD : BUS_NONE, 0, 32'(i * 8), 64'h0, resp, tag, data);
      if (i < 20) check($sformatf("b2b_resp%0d", i), 64'(resp), 64'((i % 15) + 1));
      if (i >= 4) check($sformatf("b2b_tag%0d", i), 64'(tag), 64'(((i - 4) % 15) + 1));
      else        check($sformatf("b2b_tag%0d", i), 64'(tag), 64'd0);
    end

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic        b;
      BUS_COMMAND  c;
      logic [31:0] a;
      logic [63:0] d;
      r = ($urandom_range(0, 59) != 0);
      b = ($urandom_range(0, 3) == 0);
      c = BUS_COMMAND'($urandom_range(0, 2));
      a = (32'($urandom_range(0, 7)) << 3) | (32'($urandom_range(0, 3)) << 9);
      d = {$urandom, $urandom};
      step(r, c, b, a, d, resp, tag, data);
    end

    for (int i = 0; i < LAT + 1; i++) step(1, BUS_NONE, 0, 32'h0, 64'h0, resp, tag, data);
    check("drain_empty", 64'(pend_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter MEM_LATENCY, default 4, cycles from load acceptance to data return; legal range 1..14.
REQ-002 Parameter MEM_WORDS, default 64, number of 64-bit words in the backing store; power of two.
REQ-003 clock  input  1  single clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Dcache2Dmem_command  input  2  BUS_NONE / BUS_LOAD / BUS_STORE request.
REQ-006 Dcache2Dmem_addr  input  32 (PC_t)  byte address; word index = addr[3 +: log2(MEM_WORDS)]; upper bits ignored, so addresses wrap.
REQ-007 Dcache2Dmem_data  input  64  store data.
REQ-008 mem_busy  input  1  backpressure; when high, no request is accepted.
REQ-009 Dmem2Dcache_response  output  4  nonzero tag when the request is accepted this cycle; 0 means not accepted.
REQ-010 Dmem2Dcache_data  output  64  load data, valid only in the completion cycle.
REQ-011 Dmem2Dcache_tag  output  4  tag of the load completing this cycle; 0 means no completion.

Function
REQ-012 Response is combinational: a nonzero response means the command, address and data are sampled at the next rising edge.
- A BUS_NONE command gets response 0.
- Any command presented while mem_busy=1 gets response 0 and changes no state.
REQ-013 Tag generator: a 4-bit counter cycling 1..15; after 15 it wraps to 1 and never produces 0.
- On acceptance of a load or a store, the response equals the current counter value, and the counter advances at that edge.
REQ-014 Load accepted in cycle C: the memory word is read at the acceptance edge, so the data is a snapshot.
- Dmem2Dcache_tag = response tag and Dmem2Dcache_data = snapshot, both during cycle C+MEM_LATENCY, for exactly one cycle.
REQ-015 Store accepted in cycle C: the memory word is written at the acceptance edge.
- Its tag is consumed, but it never appears on Dmem2Dcache_tag.
REQ-016 Load and store to the same word in consecutive accepted cycles: the later load returns the stored data.
- A load accepted before the store returns the old data.
REQ-017 At most one request is accepted per cycle, so at most one completion occurs per cycle.
- With MEM_LATENCY≤14, all outstanding tags are unique.
REQ-018 Completions are in acceptance order, through a MEM_LATENCY-deep pipeline of {valid, tag, data}.
- A load completing in the same cycle a new request is accepted is unaffected by it.
REQ-019 When no completion occurs, Dmem2Dcache_tag=0 and Dmem2Dcache_data=0.
REQ-020 mem_busy does not stall the return pipeline; in-flight loads complete on schedule.

Reset
REQ-021 While reset=0, regardless of clock:
- all pipeline valids clear;
- the tag counter is set to 1;
- the backing store clears to 0;
- Dmem2Dcache_tag and Dmem2Dcache_data read 0.
REQ-022 Reset asserted mid-operation discards all in-flight loads; no completion is ever reported for their tags.
REQ-023 Response is 0 while reset=0.
- In the first cycle after release, a request may be accepted, with tag 1.

Structure
REQ-024 The BUS_COMMAND encoding (BUS_NONE/BUS_LOAD/BUS_STORE) and PC_t come from the shared sys_defs package, not redefined locally.
REQ-025 The MEM_LATENCY and MEM_WORDS defaults are shared constants in sys_defs.svh.
REQ-026 One sub-module, dmem_return_pipe, is natural: a parameterized-depth shift register of {valid, tag[3:0], data[63:0]} with async active-low clear.

Verification
REQ-027 Reset release, load at addr 0x0000_0008 in cycle 0 -> response=1 in cycle 0; tag=1, data=0 in cycle 4; tag=0 in cycles 1-3 and 5.
REQ-028 Store 0xDEAD_BEEF_0123_4567 to 0x10 (response 1), then load 0x10 next cycle (response 2) -> tag=2 with data 0xDEAD_BEEF_0123_4567 four cycles after the load; tag 1 never appears.
REQ-029 Back-to-back loads every cycle for 20 cycles -> responses 1..15 then 1..5, with no 0; one completion per cycle, in order, starting at cycle 4.
REQ-030 mem_busy=1 with a load presented for 3 cycles -> response 0 for those cycles and counter unchanged; after mem_busy drops, the load gets the next tag and completes MEM_LATENCY cycles later.
REQ-031 Load accepted in cycle 0, reset=0 asserted in cycle 2 and released in cycle 3 -> no nonzero tag in cycles 3-6; the next accepted request gets tag 1.
REQ-032 Load 0x0 and load 0x200 with MEM_WORDS=64 (aliasing) after a store of 0x55 to 0x200 -> both return 0x55.
